cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter BEATS, default 4: number of burst beats per cache line.
REQ-002 Parameter BEAT_W, default 64: burst data width in bits; BEATS*BEAT_W SHALL equal 256.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 line_address  input  32  line-side request address from the cache (pmem_address).
REQ-006 line_read  input  1  line read request, held by requester until line_resp.
REQ-007 line_write  input  1  line write request, held by requester until line_resp.
REQ-008 line_wdata  input  256  line to write back.
REQ-009 line_rdata  output  256  assembled line from the last completed read.
REQ-010 line_resp  output  1  single-cycle completion pulse.
REQ-011 burst_address  output  32  line-aligned burst address.
REQ-012 burst_read  output  1  burst read request.
REQ-013 burst_write  output  1  burst write request.
REQ-014 burst_wdata  output  BEAT_W  current write beat.
REQ-015 burst_rdata  input  BEAT_W  read beat, valid when burst_resp=1.
REQ-016 burst_resp  input  1  beat handshake from memory, one pulse per beat.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-018 In IDLE, line_write=1 SHALL move to WRITE; else line_read=1 SHALL move to READ (write wins if both are asserted).
REQ-019 On leaving IDLE, the adaptor SHALL latch {line_address[31:5],5'b0} into burst_address, latch line_wdata for writes, and clear the beat counter to 0.
REQ-020 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE; both 0 in IDLE and DONE.
REQ-021 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line_rdata bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k] for counter value k, then increment k.
REQ-022 In WRITE, burst_wdata SHALL combinationally equal latched beat k; each burst_resp=1 SHALL increment k.
REQ-023 The state SHALL move to DONE on the burst_resp cycle where k=BEATS-1; the counter SHALL wrap to 0.
REQ-024 DONE SHALL assert line_resp for exactly one cycle, ignore line_read/line_write, and return to IDLE.
REQ-025 Latency: request sampled in IDLE at edge t gives burst_read/burst_write high from t+1; with the final beat at edge f, line_resp SHALL be high in the cycle after f.
REQ-026 line_rdata SHALL remain stable outside READ, holding the last assembled line, including across writes.
REQ-027 burst_resp in IDLE or DONE SHALL be ignored with no state, counter, or data change.
REQ-028 Non-consecutive resp beats (gaps) SHALL be tolerated; the adaptor holds state until the next pulse.
REQ-029 Address and wdata changes during a transaction SHALL have no effect (latched values are used).

Reset
REQ-030 While rst=0: state=IDLE, counter=0, burst_read=0, burst_write=0, line_resp=0, burst_address=0, line_rdata=0, latched wdata=0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no line_resp; after release the adaptor SHALL accept a new request.

Structure
REQ-032 A shared package SHALL hold the state enum, BEATS, BEAT_W, and the line-offset constant (5).
REQ-033 No sub-module: a single FSM, a 2-bit counter, and data registers.

Verification
REQ-034 Read at 0x0000_1234 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address=0x0000_1220; line_rdata={0x44..,0x33..,0x22..,0x11..}; one line_resp pulse.
REQ-035 Write line 0xDEAD...0001 with 4 consecutive resp -> burst_wdata shows beats 0..3 (low first); burst_write drops in DONE; one line_resp.
REQ-036 Read with a 3-cycle gap between beats 1 and 2 -> correct line assembled; line_resp only after the 4th beat.
REQ-037 line_read and line_write both 1 in IDLE -> WRITE taken; line_rdata unchanged.
REQ-038 rst=0 after beat 2 of a read -> outputs return to reset values within the same cycle; a fresh read after release completes correctly.
REQ-039 Spurious burst_resp while IDLE -> no line_resp, line_rdata unchanged.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adaptor_pkg
//  Purpose  : Shared types and constants for the cache-line <-> burst adaptor:
//             FSM state encoding, burst geometry and the line-offset width.
//  Revision : 1.0  initial release
// ============================================================================
package cacheline_adaptor_pkg;

    // Burst geometry: BEATS * BEAT_W must equal the 256-bit cache line.
    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;

    // A 256-bit line spans 32 bytes, so the low 5 address bits are the offset.
    localparam int c_line_offset = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adaptor
//  Purpose  : Converts single 256-bit cache-line read/write requests into a
//             burst of BEATS transfers of BEAT_W bits each, low beat first.
//  Ports    : clk, rst (async, active-low)
//             line_address/line_read/line_write/line_wdata  -> from the cache
//             line_rdata/line_resp                          -> to the cache
//             burst_address/burst_read/burst_write/burst_wdata -> to memory
//             burst_rdata/burst_resp                        -> from memory
//  Revision : 1.0  initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int BEATS  = cacheline_adaptor_pkg::BEATS,
    parameter int BEAT_W = cacheline_adaptor_pkg::BEAT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               line_address,
    input  logic                      line_read,
    input  logic                      line_write,
    input  logic [BEATS*BEAT_W-1:0]   line_wdata,
    output logic [BEATS*BEAT_W-1:0]   line_rdata,
    output logic                      line_resp,
    output logic [31:0]               burst_address,
    output logic                      burst_read,
    output logic                      burst_write,
    output logic [BEAT_W-1:0]         burst_wdata,
    input  logic [BEAT_W-1:0]         burst_rdata,
    input  logic                      burst_resp
);

    import cacheline_adaptor_pkg::*;

    localparam int         c_line_w    = BEATS * BEAT_W;
    localparam logic [1:0] c_last_beat = 2'(BEATS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_cnt;
    logic [31:0]         r_addr;
    logic [c_line_w-1:0] r_wdata;
    logic [c_line_w-1:0] r_rdata;

    wire w_start     = (r_state == IDLE) && (line_read || line_write);
    wire w_last_beat = burst_resp && (r_cnt == c_last_beat);

    // Next-state logic; write has priority over read when both are requested.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (line_write)     w_next_state = WRITE;
                else if (line_read) w_next_state = READ;
            end
            READ:    if (w_last_beat) w_next_state = DONE;
            WRITE:   if (w_last_beat) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr <= {line_address[31:c_line_offset], {c_line_offset{1'b0}}};
                        r_cnt  <= 2'd0;
                        if (line_write) r_wdata <= line_wdata;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        r_rdata[r_cnt*BEAT_W +: BEAT_W] <= burst_rdata;
                        // Two-bit counter wraps to 0 after the final beat.
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (burst_resp) r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Request strobes and the response pulse decode straight from the state,
    // so an asynchronous reset clears them without waiting for a clock.
    assign burst_read    = (r_state == READ);
    assign burst_write   = (r_state == WRITE);
    assign line_resp     = (r_state == DONE);
    assign burst_address = r_addr;
    assign burst_wdata   = r_wdata[r_cnt*BEAT_W +: BEAT_W];
    assign line_rdata    = r_rdata;

endmodule
`default_nettype wire
